alu_seq: RTL and testbench

//   Parametrised, handshaked, registered ALU. Successor to the fixed 4-input/1-output sequential alu.

---
 rtl/alu_seq.sv | 143 ++++++++++++++
 tb/tb_alu_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with accumulator, per-result {Z,N,C,V} flags and
// sticky flag accumulation. One-cycle latency, full throughput on valid/ready.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit STICKY = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [3:0]       out_flags,
    input  logic             flags_clr,
    output logic [3:0]       sticky_flags
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOR   = 3'b101;
    localparam logic [2:0] OP_SHL   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // Returns {R, Z, N, C, V}; SUB carry is the inverted borrow (set when A >= B).
    function automatic logic [WIDTH+3:0] alu_eval(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        wide = {(WIDTH+1){1'b0}};
        r    = {WIDTH{1'b0}};
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = ~wide[WIDTH];
                v    = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOR:   r = ~(a | b);
            OP_SHL: begin
                r = {a[WIDTH-2:0], 1'b0};
                c = a[WIDTH-1];
            end
            OP_PASSB: r = b;
            default:  r = b;
        endcase
        return {r, (r == {WIDTH{1'b0}}), r[WIDTH-1], c, v};
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_res_q,   out_res_d;
    logic [3:0]       out_flags_q, out_flags_d;
    logic [3:0]       sticky_q,    sticky_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic             accept_s;
    logic             consume_s;
    logic [WIDTH-1:0] opa_s;
    logic [WIDTH+3:0] eval_s;

    assign in_ready     = !out_valid_q || out_ready;
    assign out_valid    = out_valid_q;
    assign out_res      = out_res_q;
    assign out_flags    = out_flags_q;
    assign sticky_flags = sticky_q;

    // Handshake decode, ALU evaluation and next-state selection.
    always_comb begin
        accept_s    = in_valid && in_ready;
        consume_s   = out_valid_q && out_ready;
        opa_s       = in_use_acc ? acc_q : in_a;
        eval_s      = alu_eval(in_op, opa_s, in_b);
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_flags_d = out_flags_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_res_d   = eval_s[WIDTH+3:4];
            out_flags_d = eval_s[3:0];
            acc_d       = eval_s[WIDTH+3:4];
        end else if (consume_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // A clear concurrent with an accept still records the new op's flags.
        if (!STICKY) begin
            sticky_d = 4'b0000;
        end else if (flags_clr && accept_s) begin
            sticky_d = eval_s[3:0];
        end else if (flags_clr) begin
            sticky_d = 4'b0000;
        end else if (accept_s) begin
            sticky_d = sticky_q | eval_s[3:0];
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers; reset discards any pending result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_res_q   <= {WIDTH{1'b0}};
            out_flags_q <= 4'b0000;
            sticky_q    <= 4'b0000;
            acc_q       <= {WIDTH{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_flags_q <= out_flags_d;
            sticky_q    <= sticky_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8, STICKY=1): directed vector table,
// hand-written stall/clear/reset sequences and randomized traffic vs a reference model.
module tb_alu_seq;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_use_acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_res;
    logic [3:0] out_flags;
    logic       flags_clr;
    logic [3:0] sticky_flags;

    int tests;
    int fails;

    // Reference state, expressed as the observable beat plus accumulator and sticky flags
    bit         m_valid;
    int         m_res;
    logic [3:0] m_flags;
    int         m_acc;
    logic [3:0] m_sticky;

    alu_seq #(.WIDTH(8), .STICKY(1'b1)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_use_acc   (in_use_acc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_flags    (out_flags),
        .flags_clr    (flags_clr),
        .sticky_flags (sticky_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        bit         use_acc;
        bit         clr;
        logic [7:0] exp_res;
        logic [3:0] exp_flags;
        logic [3:0] exp_sticky;
    } vec_t;

    vec_t vecs[16];

    // Reference ALU from plain integer arithmetic: returns {R[7:0], Z, N, C, V}
    function automatic logic [11:0] ref_alu(input logic [2:0] op, input int a, input int b);
        int r, sa, sb, s;
        bit c, v;
        r = 0; s = 0; c = 1'b0; v = 1'b0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            3'd0: begin r = (a + b) % 256; c = (a + b) >= 256; s = sa + sb; v = (s > 127) || (s < -128); end
            3'd1: begin r = (a - b + 256) % 256; c = (a >= b); s = sa - sb; v = (s > 127) || (s < -128); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = 255 - (a | b);
            3'd6: begin r = (a * 2) % 256; c = (a >= 128); end
            default: r = b;
        endcase
        return {r[7:0], (r == 0), (r >= 128), c, v};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, update model at the edge, check just after it.
    task automatic cycle(input bit iv, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit ua, input bit ordy, input bit clr);
        bit         acc_ok;
        logic [11:0] ref_v;
        @(negedge clock);
        in_valid   = iv;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_use_acc = ua;
        out_ready  = ordy;
        flags_clr  = clr;
        #1;
        check("in_ready", {15'd0, in_ready}, {15'd0, (!m_valid || ordy)});
        @(posedge clock);
        acc_ok = iv && (!m_valid || ordy);
        if (acc_ok) begin
            ref_v    = ref_alu(op, ua ? m_acc : int'(a), int'(b));
            m_res    = int'(ref_v[11:4]);
            m_flags  = ref_v[3:0];
            m_acc    = m_res;
            m_valid  = 1'b1;
            m_sticky = clr ? m_flags : (m_sticky | m_flags);
        end else begin
            if (ordy) m_valid = 1'b0;
            if (clr) m_sticky = 4'b0000;
        end
        #1;
        check("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
        if (m_valid) begin
            check("out_res", {8'd0, out_res}, m_res[15:0]);
            check("out_flags", {12'd0, out_flags}, {12'd0, m_flags});
        end
        check("sticky", {12'd0, sticky_flags}, {12'd0, m_sticky});
    endtask

    task automatic do_reset();
        @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_res", {8'd0, out_res}, 16'd0);
        check("rst_out_flags", {12'd0, out_flags}, 16'd0);
        check("rst_sticky", {12'd0, sticky_flags}, 16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        m_valid  = 1'b0;
        m_res    = 0;
        m_flags  = 4'b0000;
        m_acc    = 0;
        m_sticky = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_valid = 1'b0; m_res = 0; m_flags = 4'b0000; m_acc = 0; m_sticky = 4'b0000;
        reset_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = 8'h00; in_b = 8'h00;
        in_use_acc = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;

        //          op      a      b      acc   clr   res    flags    sticky
        vecs[0]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b0101, 4'b0101};
        vecs[1]  = '{3'd1, 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 4'b1010, 4'b1010};
        vecs[2]  = '{3'd1, 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 4'b0100, 4'b1110};
        vecs[3]  = '{3'd7, 8'h00, 8'h10, 1'b0, 1'b0, 8'h10, 4'b0000, 4'b1110};
        vecs[4]  = '{3'd0, 8'h00, 8'hF0, 1'b1, 1'b0, 8'h00, 4'b1010, 4'b1110};
        vecs[5]  = '{3'd0, 8'hAA, 8'h05, 1'b1, 1'b0, 8'h05, 4'b0000, 4'b1110};
        vecs[6]  = '{3'd2, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'h0F, 4'b0000, 4'b1110};
        vecs[7]  = '{3'd3, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 4'b0100, 4'b1110};
        vecs[8]  = '{3'd4, 8'hAA, 8'hAA, 1'b0, 1'b0, 8'h00, 4'b1000, 4'b1110};
        vecs[9]  = '{3'd5, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 4'b0100, 4'b1110};
        vecs[10] = '{3'd5, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 4'b1000, 4'b1110};
        vecs[11] = '{3'd6, 8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 4'b0010, 4'b1110};
        vecs[12] = '{3'd6, 8'h40, 8'h00, 1'b0, 1'b0, 8'h80, 4'b0100, 4'b1110};
        vecs[13] = '{3'd1, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 4'b0011, 4'b1111};
        vecs[14] = '{3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1010, 4'b1111};
        vecs[15] = '{3'd0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 4'b1011, 4'b1111};

        repeat (2) @(negedge clock);
        #1;
        check("init_out_valid", {15'd0, out_valid}, 16'd0);
        check("init_sticky", {12'd0, sticky_flags}, 16'd0);
        check("init_in_ready", {15'd0, in_ready}, 16'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed table, back-to-back with the consumer always ready
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_acc, 1'b1, vecs[i].clr);
            check("vec_res", {8'd0, out_res}, {8'd0, vecs[i].exp_res});
            check("vec_flags", {12'd0, out_flags}, {12'd0, vecs[i].exp_flags});
            check("vec_sticky", {12'd0, sticky_flags}, {12'd0, vecs[i].exp_sticky});
        end

        // Stall: one accept, then three cycles of backpressure, then release
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 3'd0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'd1, 8'h09, 8'h01, 1'b0, 1'b0, 1'b0);
            check("stall_hold_res", {8'd0, out_res}, 16'h0003);
            check("stall_in_ready", {15'd0, in_ready}, 16'd0);
        end
        cycle(1'b1, 3'd1, 8'h09, 8'h01, 1'b0, 1'b1, 1'b0);
        check("stall_release_res", {8'd0, out_res}, 16'h0008);

        // Sticky clear with and without a concurrent accept
        cycle(1'b1, 3'd7, 8'h00, 8'h80, 1'b0, 1'b1, 1'b1);
        check("clr_setup_sticky", {12'd0, sticky_flags}, 16'h0004);
        cycle(1'b1, 3'd2, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b1);
        check("clr_accept_sticky", {12'd0, sticky_flags}, 16'h0008);
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check("clr_only_sticky", {12'd0, sticky_flags}, 16'h0000);

        // Reset while a result is stalled; accumulator must come back as zero
        cycle(1'b1, 3'd0, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("post_rst_no_replay", {15'd0, out_valid}, 16'd0);
        cycle(1'b1, 3'd0, 8'h55, 8'h07, 1'b1, 1'b1, 1'b0);
        check("post_rst_acc", {8'd0, out_res}, 16'h0007);

        // Randomized traffic with random valid, backpressure and clears
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
